// File: rtl/collision_monitor.sv
`default_nettype none
// ============================================================================
// Module   : collision_monitor
// Purpose  : Per-pixel dino/obstacle overlap counter with a frame-streak
//            confirmation FSM that drives a sticky collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module collision_monitor #(
    parameter int ScreenW       = 640,
    parameter int ScreenH       = 480,
    parameter int HitThreshold  = 4,
    parameter int ConfirmFrames = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] vgaX,
    input  logic [8:0] vgaY,
    input  logic       dinoPix,
    input  logic       obsPix,
    input  logic [1:0] gameState,
    output logic       collided,
    output logic [9:0] hitCount,
    output logic       frameDone
);

    localparam logic [10:0] c_SCREEN_W = 11'(ScreenW);
    localparam logic [9:0]  c_SCREEN_H = 10'(ScreenH);
    localparam logic [9:0]  c_LAST_X   = 10'(ScreenW - 1);
    localparam logic [8:0]  c_LAST_Y   = 9'(ScreenH - 1);
    localparam logic [9:0]  c_THRESH   = 10'(HitThreshold);
    localparam logic [2:0]  c_CONFIRM  = 3'(ConfirmFrames);
    localparam logic [1:0]  c_GS_INIT  = 2'b00;
    localparam logic [1:0]  c_GS_PLAY  = 2'b01;

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_ARMED = 2'd1;
    localparam logic [1:0]  c_HIT   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_stateNext;
    logic [2:0]  r_streak;
    logic [2:0]  w_streakNext;
    logic [2:0]  w_streakInc;
    logic [9:0]  r_acc;
    logic [9:0]  r_prevX;
    logic [8:0]  r_prevY;
    logic        r_collided;
    logic [9:0]  r_hitCount;
    logic        r_frameDone;
    logic        w_onScreen;
    logic        w_overlap;
    logic        w_atEnd;
    logic        w_prevAtEnd;
    logic        w_frameEnd;
    logic [10:0] w_sum;
    logic [9:0]  w_total;

    assign w_onScreen  = ({1'b0, vgaX} < c_SCREEN_W) && ({1'b0, vgaY} < c_SCREEN_H);
    assign w_overlap   = dinoPix & obsPix & w_onScreen;
    assign w_atEnd     = (vgaX == c_LAST_X) && (vgaY == c_LAST_Y);
    assign w_prevAtEnd = (r_prevX == c_LAST_X) && (r_prevY == c_LAST_Y);
    // A scan that dwells on the last pixel must still produce only one frame end.
    assign w_frameEnd  = w_atEnd && !w_prevAtEnd;

    assign w_sum       = {1'b0, r_acc} + {10'd0, w_overlap};
    assign w_total     = w_sum[10] ? 10'h3FF : w_sum[9:0];
    assign w_streakInc = r_streak + 3'd1;

    always_comb begin
        w_stateNext  = r_state;
        w_streakNext = r_streak;
        case (r_state)
            c_IDLE: begin
                w_streakNext = 3'd0;
                if (w_frameEnd && gameState == c_GS_PLAY) begin
                    w_stateNext = c_ARMED;
                end
            end
            c_ARMED: begin
                if (gameState == c_GS_INIT) begin
                    w_stateNext  = c_IDLE;
                    w_streakNext = 3'd0;
                end else if (w_frameEnd) begin
                    if (gameState != c_GS_PLAY) begin
                        w_stateNext  = c_IDLE;
                        w_streakNext = 3'd0;
                    end else if (w_total >= c_THRESH) begin
                        w_streakNext = w_streakInc;
                        if (w_streakInc == c_CONFIRM) begin
                            w_stateNext = c_HIT;
                        end
                    end else begin
                        w_streakNext = 3'd0;
                    end
                end
            end
            c_HIT: begin
                if (gameState == c_GS_INIT) begin
                    w_stateNext  = c_IDLE;
                    w_streakNext = 3'd0;
                end
            end
            default: begin
                w_stateNext  = c_IDLE;
                w_streakNext = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_streak    <= 3'd0;
            r_acc       <= 10'd0;
            r_prevX     <= 10'h3FF;
            r_prevY     <= 9'h1FF;
            r_collided  <= 1'b0;
            r_hitCount  <= 10'd0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_streak    <= w_streakNext;
            r_prevX     <= vgaX;
            r_prevY     <= vgaY;
            r_collided  <= (w_stateNext == c_HIT);
            r_frameDone <= w_frameEnd;
            if (w_frameEnd) begin
                r_hitCount <= w_total;
                r_acc      <= 10'd0;
            end else begin
                r_acc      <= w_total;
            end
        end
    end

    assign collided  = r_collided;
    assign hitCount  = r_hitCount;
    assign frameDone = r_frameDone;

endmodule
`default_nettype wire
